// File: rtl/signed_bcd_unpack_if.sv
// Request/result bundle for the signed display-word decoder.
// The master side drives start and the display word; the slave side returns the decoded fields.
interface signed_bcd_unpack_if #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
);
    logic                  start;
    logic [4*DIGITS-1:0]   signedBCD;
    logic                  busy;
    logic                  done;
    logic                  signBit;
    logic [4*DIGITS-1:0]   BCD;
    logic [BIN_W-1:0]      binary;
    logic [2:0]            digitCount;
    logic                  error;

    modport master (
        output start, signedBCD,
        input  busy, done, signBit, BCD, binary, digitCount, error
    );

    modport slave (
        input  start, signedBCD,
        output busy, done, signBit, BCD, binary, digitCount, error
    );
endinterface

// File: rtl/signed_bcd_unpack.sv
// Decodes a signed display word (F blank, E minus, 0-9 digits) one nibble per clock, MSB first.
// Optional build macro ERROR_ABORT_EN: finish on the first malformed nibble instead of scanning all of them.
module signed_bcd_unpack #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    signed_bcd_unpack_if.slave bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {LEAD = 2'd0, SIGN = 2'd1, NUM = 2'd2} phase_t;

    state_t              state_r;
    phase_t              phase_r;
    phase_t              phase_nxt_s;
    logic [4*DIGITS-1:0] word_r;
    logic [IDX_W-1:0]    idx_r;
    logic [BIN_W-1:0]    bin_acc_r;
    logic [4*DIGITS-1:0] bcd_acc_r;
    logic [2:0]          cnt_r;
    logic                neg_r;
    logic                err_r;
    logic                end_r;

    logic                busy_r;
    logic                done_r;
    logic                sign_r;
    logic [4*DIGITS-1:0] bcd_r;
    logic [BIN_W-1:0]    bin_r;
    logic [2:0]          cnt_out_r;
    logic                error_r;

    logic [3:0]          nib_s;
    logic                nib_err_s;
    logic                is_digit_s;
    logic [BIN_W-1:0]    bin_nxt_s;
    logic                fin_err_s;
    logic                fin_neg_s;

    assign nib_s = word_r[{idx_r, 2'b00} +: 4];

    // Classify the current nibble against the blank/sign/digit grammar.
    always_comb begin
        nib_err_s   = 1'b0;
        is_digit_s  = 1'b0;
        phase_nxt_s = phase_r;
        case (nib_s)
            4'hF: begin
                if (phase_r != LEAD) nib_err_s = 1'b1;
                else                 phase_nxt_s = LEAD;
            end
            4'hE: begin
                if (phase_r != LEAD) nib_err_s = 1'b1;
                else                 phase_nxt_s = SIGN;
            end
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                is_digit_s  = 1'b1;
                phase_nxt_s = NUM;
            end
            default: nib_err_s = 1'b1;
        endcase
        bin_nxt_s = bin_acc_r * BIN_W'(10) + BIN_W'(nib_s);
        // A minus sign in front of an all-zero magnitude reports as plain zero.
        fin_err_s = err_r | (phase_r != NUM);
        fin_neg_s = neg_r & (bcd_acc_r != {4*DIGITS{1'b0}});
    end

    // Control FSM, scan datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            phase_r   <= LEAD;
            word_r    <= {4*DIGITS{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            bin_acc_r <= {BIN_W{1'b0}};
            bcd_acc_r <= {4*DIGITS{1'b0}};
            cnt_r     <= 3'd0;
            neg_r     <= 1'b0;
            err_r     <= 1'b0;
            end_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sign_r    <= 1'b0;
            bcd_r     <= {4*DIGITS{1'b0}};
            bin_r     <= {BIN_W{1'b0}};
            cnt_out_r <= 3'd0;
            error_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        word_r    <= bus.signedBCD;
                        idx_r     <= IDX_W'(DIGITS - 1);
                        phase_r   <= LEAD;
                        bin_acc_r <= {BIN_W{1'b0}};
                        bcd_acc_r <= {4*DIGITS{1'b0}};
                        cnt_r     <= 3'd0;
                        neg_r     <= 1'b0;
                        err_r     <= 1'b0;
                        end_r     <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= SCAN;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                SCAN: begin
                    if (end_r) begin
                        // One resolve step after the last nibble publishes the result.
                        state_r   <= DONE;
                        done_r    <= 1'b1;
                        error_r   <= fin_err_s;
                        sign_r    <= fin_err_s ? 1'b0 : fin_neg_s;
                        bcd_r     <= fin_err_s ? {4*DIGITS{1'b0}} : bcd_acc_r;
                        bin_r     <= fin_err_s ? {BIN_W{1'b0}} : bin_acc_r;
                        cnt_out_r <= fin_err_s ? 3'd0 : cnt_r;
                    end else if (nib_err_s) begin
`ifdef ERROR_ABORT_EN
                        state_r   <= DONE;
                        done_r    <= 1'b1;
                        error_r   <= 1'b1;
                        sign_r    <= 1'b0;
                        bcd_r     <= {4*DIGITS{1'b0}};
                        bin_r     <= {BIN_W{1'b0}};
                        cnt_out_r <= 3'd0;
`else
                        err_r     <= 1'b1;
                        if (idx_r == {IDX_W{1'b0}}) end_r <= 1'b1;
                        else                        idx_r <= idx_r - IDX_W'(1);
`endif
                    end else begin
                        phase_r <= phase_nxt_s;
                        if (nib_s == 4'hE) neg_r <= 1'b1;
                        else               neg_r <= neg_r;
                        if (is_digit_s) begin
                            bin_acc_r                      <= bin_nxt_s;
                            bcd_acc_r[{idx_r, 2'b00} +: 4] <= nib_s;
                            cnt_r                          <= cnt_r + 3'd1;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                        if (idx_r == {IDX_W{1'b0}}) end_r <= 1'b1;
                        else                        idx_r <= idx_r - IDX_W'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.signBit    = sign_r;
    assign bus.BCD        = bcd_r;
    assign bus.binary     = bin_r;
    assign bus.digitCount = cnt_out_r;
    assign bus.error      = error_r;
endmodule

// File: tb/tb_signed_bcd_unpack.sv
// Scoreboard bench for signed_bcd_unpack: expected results are queued at each accepted start
// and compared, including done timing, whenever the decoder pulses done.
module tb_signed_bcd_unpack;
    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        logic        sign;
        logic [23:0] bcd;
        logic [19:0] bin;
        logic [2:0]  cnt;
        logic        err;
        int          due;
    } exp_t;

    exp_t q[$];

    signed_bcd_unpack_if #(.DIGITS(6), .BIN_W(20)) bus_if ();

    signed_bcd_unpack #(.DIGITS(6), .BIN_W(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference decode of a display word, nibble by nibble from the MSB.
    function automatic exp_t model(input logic [23:0] w);
        exp_t       e;
        int         ph;
        int         first;
        bit         neg;
        bit         bad;
        logic [3:0] n;
        e = '{default: 0};
        ph = 0; first = 0; neg = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            n = w[i*4 +: 4];
            bad = 1'b0;
            if (n == 4'hF) begin
                if (ph != 0) bad = 1'b1;
            end else if (n == 4'hE) begin
                if (ph != 0) bad = 1'b1;
                else begin ph = 1; neg = 1'b1; end
            end else if (n <= 4'd9) begin
                ph = 2;
                e.bin = 20'(e.bin * 20'd10 + 20'(n));
                e.bcd[i*4 +: 4] = n;
                e.cnt = e.cnt + 3'd1;
            end else begin
                bad = 1'b1;
            end
            if (bad && first == 0) first = 6 - i;
        end
        if (first != 0 || ph != 2) begin
            e = '{default: 0};
            e.err = 1'b1;
        end else begin
            e.sign = neg && (e.bin != 20'd0);
        end
`ifdef ERROR_ABORT_EN
        e.due = (first != 0) ? first : 7;
`else
        e.due = 7;
`endif
        return e;
    endfunction

    // Present a word with start for one edge; optionally queue its expected result.
    task automatic send(input logic [23:0] w, input bit push);
        exp_t e;
        @(negedge clk);
        bus_if.signedBCD = w;
        bus_if.start     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        check("accept_busy", 32'(bus_if.busy), 32'd1);
        if (push) begin
            e = model(w);
            e.due = cyc + e.due;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus_if.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(bus_if.busy), 32'd0);
    endtask

    // Compare every done pulse against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus_if.done) begin
            if (q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.due));
                check("busy_at_done", 32'(bus_if.busy), 32'd1);
                check("signBit", 32'(bus_if.signBit), 32'(e.sign));
                check("BCD", 32'(bus_if.BCD), 32'(e.bcd));
                check("binary", 32'(bus_if.binary), 32'(e.bin));
                check("digitCount", 32'(bus_if.digitCount), 32'(e.cnt));
                check("error", 32'(bus_if.error), 32'(e.err));
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_done"}, 32'(bus_if.done), 32'd0);
        check({tag, "_sign"}, 32'(bus_if.signBit), 32'd0);
        check({tag, "_bcd"}, 32'(bus_if.BCD), 32'd0);
        check({tag, "_bin"}, 32'(bus_if.binary), 32'd0);
        check({tag, "_cnt"}, 32'(bus_if.digitCount), 32'd0);
        check({tag, "_err"}, 32'(bus_if.error), 32'd0);
    endtask

    initial begin
        int n;
        reset            = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.signedBCD = 24'h000000;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;

        // Case 1: single minus digit.
        wait_idle();
        send(24'hFFFFE7, 1'b1);

        // Case 2: full word, then a signed word back-to-back.
        wait_idle();
        send(24'h123456, 1'b1);
        repeat (8) @(negedge clk);
        send(24'hE12345, 1'b1);

        // Case 3: malformed words.
        wait_idle();
        send(24'hFF1F23, 1'b1);
        wait_idle();
        send(24'hFFFFFF, 1'b1);
        wait_idle();
        send(24'hFFFFFE, 1'b1);

        // Case 4: negative zero and a hex nibble.
        wait_idle();
        send(24'hFFFFE0, 1'b1);
        wait_idle();
        send(24'hFFFF0A, 1'b1);
        wait_idle();
        send(24'hF00012, 1'b1);

        // Case 5: start pulses during the scan are ignored.
        wait_idle();
        send(24'hE00321, 1'b1);
        @(negedge clk);
        bus_if.signedBCD = 24'h999999;
        bus_if.start     = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;

        // Case 6: reset on the third scan cycle aborts with no done.
        wait_idle();
        send(24'h123456, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_cleared("midreset");
        repeat (10) @(negedge clk);
        check("no_done_after_reset", 32'(bus_if.done), 32'd0);
        send(24'h000042, 1'b1);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(q.size()), 32'd0);
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
